// File: rtl/bcd_pkg.sv
// Shared constants and types for the packed-BCD adder.
package bcd_pkg;

  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_is_bad(input bcd_digit_t d);
    return d > 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal adder: binary add, then +6 correction when the sum exceeds nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co,
  output logic       bad
);

  logic [4:0] w_sum;
  logic [3:0] w_corr;

  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    // Only the low nibble of the corrected value is kept, so wrap-around is intended.
    w_corr = w_sum[3:0] + 4'(BCD_CORR);
    co     = w_sum > 5'(BCD_MAX);
    s      = co ? w_corr : w_sum[3:0];
    bad    = bcd_is_bad(a) | bcd_is_bad(b);
  end

endmodule

// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: combinational ripple of digit adders into one output register stage.
module bcd_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Cin,
  output logic [4*DIGITS-1:0]   Sum,
  output logic                  Cout,
  output logic                  out_valid,
  output logic                  err
);

  logic [DIGITS:0]     w_carry;
  logic [4*DIGITS-1:0] w_sum;
  logic [DIGITS-1:0]   w_bad;

  logic [4*DIGITS-1:0] r_sum;
  logic                r_cout;
  logic                r_err;
  logic                r_valid;

  assign w_carry[0] = Cin;

  for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_digit
    bcd_digit_add u_digit (
      .a   (A[4*gi +: 4]),
      .b   (B[4*gi +: 4]),
      .ci  (w_carry[gi]),
      .s   (w_sum[4*gi +: 4]),
      .co  (w_carry[gi+1]),
      .bad (w_bad[gi])
    );
  end

  // Result registers hold across idle cycles; only the valid flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (in_valid) begin
      r_sum   <= w_sum;
      r_cout  <= w_carry[DIGITS];
      r_err   <= |w_bad;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign err       = r_err;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_bcd_adder.sv
// Bench for bcd_adder: 1-digit and 4-digit instances checked against a decimal model and literals.
module tb_bcd_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v1 = 1'b0, c1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic [3:0]  sum1;
  logic        cout1, vld1, err1;

  logic        v4 = 1'b0, c4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic [15:0] sum4;
  logic        cout4, vld4, err4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] m1_sum = '0, m4_sum = '0;
  logic        m1_cout = 0, m1_err = 0, m1_vld = 0;
  logic        m4_cout = 0, m4_err = 0, m4_vld = 0;

  always #5 clk = ~clk;

  bcd_adder #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .Sum(sum1), .Cout(cout1), .out_valid(vld1), .err(err1)
  );

  bcd_adder #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .Cin(c4),
    .Sum(sum4), .Cout(cout4), .out_valid(vld4), .err(err4)
  );

  // Returns {err, cout, sum}. Legal operands use plain decimal arithmetic; otherwise the
  // per-digit correction rule is applied as stated for non-BCD digits.
  function automatic logic [33:0] model_add(input int nd, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
    logic [31:0] s;
    bit          legal;
    int          av, bv, p, tot, rem, c, dsum;
    s = '0; legal = 1; av = 0; bv = 0; p = 1;
    for (int i = 0; i < nd; i++) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) legal = 0;
      av += int'(a[4*i +: 4]) * p;
      bv += int'(b[4*i +: 4]) * p;
      p  *= 10;
    end
    if (legal) begin
      tot = av + bv + int'(cin);
      rem = tot % p;
      for (int i = 0; i < nd; i++) begin
        s[4*i +: 4] = 4'(rem % 10);
        rem /= 10;
      end
      return {1'b0, tot >= p, s};
    end
    c = int'(cin);
    for (int i = 0; i < nd; i++) begin
      dsum = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (dsum > 9) begin
        s[4*i +: 4] = 4'((dsum + 6) % 16);
        c = 1;
      end else begin
        s[4*i +: 4] = 4'(dsum);
        c = 0;
      end
    end
    return {1'b1, c[0], s};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [33:0] r;
    if (rst) begin
      m1_sum = '0; m1_cout = 0; m1_err = 0; m1_vld = 0;
      m4_sum = '0; m4_cout = 0; m4_err = 0; m4_vld = 0;
    end else begin
      if (v1) begin
        r = model_add(1, 32'(a1), 32'(b1), c1);
        m1_sum = r[31:0]; m1_cout = r[32]; m1_err = r[33]; m1_vld = 1;
      end else m1_vld = 0;
      if (v4) begin
        r = model_add(4, 32'(a4), 32'(b4), c4);
        m4_sum = r[31:0]; m4_cout = r[32]; m4_err = r[33]; m4_vld = 1;
      end else m4_vld = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_vld1",  32'(vld1),  32'(m1_vld));
      chk("m_sum1",  32'(sum1),  m1_sum);
      chk("m_cout1", 32'(cout1), 32'(m1_cout));
      chk("m_err1",  32'(err1),  32'(m1_err));
      chk("m_vld4",  32'(vld4),  32'(m4_vld));
      chk("m_sum4",  32'(sum4),  m4_sum);
      chk("m_cout4", 32'(cout4), 32'(m4_cout));
      chk("m_err4",  32'(err4),  32'(m4_err));
    end
  end

  task automatic step1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] es, input logic ec, input logic ee);
    a1 = a; b1 = b; c1 = c; v1 = 1'b1;
    @(negedge clk);
    chk("d1_sum",  32'(sum1),  32'(es));
    chk("d1_cout", 32'(cout1), 32'(ec));
    chk("d1_err",  32'(err1),  32'(ee));
    chk("d1_vld",  32'(vld1),  32'd1);
  endtask

  task automatic step4(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec);
    a4 = a; b4 = b; c4 = c; v4 = 1'b1;
    @(negedge clk);
    chk("d4_sum",  32'(sum4),  32'(es));
    chk("d4_cout", 32'(cout4), 32'(ec));
    chk("d4_vld",  32'(vld4),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] m;

    // Model pinned to hand-computed values.
    m = model_add(1, 32'h9, 32'h9, 1'b1);    chk("pin_991", m, {2'b01, 32'h9});
    m = model_add(4, 32'h1234, 32'h8766, 1'b0); chk("pin_ripple", m, {2'b01, 32'h0});
    m = model_add(1, 32'hC, 32'h1, 1'b0);    chk("pin_badC", m, {2'b11, 32'h3});
    m = model_add(1, 32'hF, 32'h0, 1'b0);    chk("pin_badF", m, {2'b11, 32'h5});

    @(negedge clk); @(negedge clk);
    chk("rst_vld1", 32'(vld1), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);
    chk("rst_vld4", 32'(vld4), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < 2; c++) begin
          a1 = 4'(a); b1 = 4'(b); c1 = c[0]; v1 = 1'b1;
          @(negedge clk);
        end

    step1(4'd5, 4'd4, 1'b0, 4'd9, 1'b0, 1'b0);
    step1(4'd5, 4'd4, 1'b1, 4'd0, 1'b1, 1'b0);
    step1(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step1(4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);
    step1(4'hC, 4'h1, 1'b0, 4'h3, 1'b1, 1'b1);
    step1(4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
    step1(4'hF, 4'h0, 1'b0, 4'h5, 1'b1, 1'b1);
    v1 = 1'b0;

    step4(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1);
    step4(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1);
    step4(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0);
    step4(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0);
    step4(16'h4567, 16'h2211, 1'b0, 16'h6778, 1'b0);
    v4 = 1'b0;
    @(negedge clk);
    chk("hold_vld",  32'(vld4),  32'd0);
    chk("hold_sum",  32'(sum4),  32'h6778);
    chk("hold_cout", 32'(cout4), 32'd0);

    // Reset wins over a simultaneous valid input.
    a4 = 16'h5555; b4 = 16'h5555; c4 = 1'b1; v4 = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rstv_sum",  32'(sum4),  32'd0);
    chk("rstv_cout", 32'(cout4), 32'd0);
    chk("rstv_vld",  32'(vld4),  32'd0);
    rst = 1'b0;

    step4(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0);
    v4 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstm_sum", 32'(sum4), 32'd0);
    chk("rstm_vld", 32'(vld4), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_vld", 32'(vld4), 32'd0);
    step4(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0);
    v4 = 1'b0;
    @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
